fetch_unit: RTL and testbench

- Instruction-fetch initiator that produces the PC, PC+4 and instruction word consumed by the IF/ID pipeline latch.
- Owns the program counter and drives a single-outstanding-request read port to the instruction memory/cache.
- Holds the fetched word in an output slot until the downstream latch accepts it.
- Handles redirects (branch/jump/flush) at any time, including while a memory request is in flight.

---
 rtl/fetch_unit.sv | 97 +++++++++
 tb/tb_fetch_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch initiator: owns the PC, issues single-outstanding reads,
// and holds the fetched word in an output slot for the IF/ID latch.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000060
) (
    input  logic        clk,
    input  logic        rst,
    output logic        i_read,
    output logic [31:0] i_address,
    input  logic        i_resp,
    input  logic [31:0] i_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        latch_ready,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4_out,
    output logic [31:0] instr_out
);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] DROP  = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] drop_addr;
    logic [31:0] target;
    logic [31:0] pc_next4;

    assign target    = redirect_pc & 32'hFFFF_FFFC;
    assign pc_next4  = pc + 32'd4;
    assign i_read    = !rst && ((state == FETCH) || (state == DROP));
    assign i_address = (state == DROP) ? drop_addr : pc;

    // PC, state and stale-request address sequencing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            drop_addr <= 32'd0;
        end else begin
            case (state)
                FETCH: begin
                    if (i_resp && !redirect) begin
                        pc    <= pc_next4;
                        state <= WAIT;
                    end else if (i_resp) begin
                        pc <= target;
                    end else if (redirect) begin
                        drop_addr <= pc;
                        pc        <= target;
                        state     <= DROP;
                    end
                end
                DROP: begin
                    if (redirect)
                        pc <= target;
                    if (i_resp)
                        state <= FETCH;
                end
                WAIT: begin
                    if (redirect) begin
                        pc    <= target;
                        state <= FETCH;
                    end else if (latch_ready) begin
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    // Output slot: load on a clean response, squash on accept or redirect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out    <= 1'b0;
            pc_out       <= 32'd0;
            pc_plus4_out <= 32'd0;
            instr_out    <= 32'd0;
        end else if (state == FETCH && i_resp && !redirect) begin
            valid_out    <= 1'b1;
            pc_out       <= pc;
            pc_plus4_out <= pc_next4;
            instr_out    <= i_rdata;
        end else if (state == WAIT && (redirect || latch_ready)) begin
            valid_out <= 1'b0;
        end
    end

    // A response with no request outstanding is a memory-side bug
    illegal_resp: assert property (
        @(posedge clk) disable iff (rst) !(i_resp && state == WAIT)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
// Each task drives one scenario and checks the outputs inline.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_read;
    logic [31:0] i_address;
    logic        i_resp = 1'b0;
    logic [31:0] i_rdata = 32'd0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        latch_ready = 1'b0;
    logic        valid_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_out;
    logic [31:0] instr_out;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.RESET_PC(32'h00000060)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address),
        .i_resp(i_resp), .i_rdata(i_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .latch_ready(latch_ready),
        .valid_out(valid_out), .pc_out(pc_out),
        .pc_plus4_out(pc_plus4_out), .instr_out(instr_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (i_read !== 1'b0) begin errors++; $display("FAIL rst_read got %b exp 0", i_read); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", valid_out); end
        checks++; if (pc_out !== 32'd0) begin errors++; $display("FAIL rst_pc got %h exp 0", pc_out); end
        checks++; if (pc_plus4_out !== 32'd0) begin errors++; $display("FAIL rst_pc4 got %h exp 0", pc_plus4_out); end
        checks++; if (instr_out !== 32'd0) begin errors++; $display("FAIL rst_instr got %h exp 0", instr_out); end
        rst = 1'b0;
        #1;
        checks++; if (i_read !== 1'b1) begin errors++; $display("FAIL first_read got %b exp 1", i_read); end
        checks++; if (i_address !== 32'h60) begin errors++; $display("FAIL first_addr got %h exp 60", i_address); end
    endtask

    task automatic test_first_fetch();
        tick();
        checks++; if (i_address !== 32'h60) begin errors++; $display("FAIL ff_addr_hold got %h exp 60", i_address); end
        tick();
        i_resp = 1'b1; i_rdata = 32'h00000013;
        tick();
        i_resp = 1'b0;
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL ff_valid got %b exp 1", valid_out); end
        checks++; if (pc_out !== 32'h60) begin errors++; $display("FAIL ff_pc got %h exp 60", pc_out); end
        checks++; if (pc_plus4_out !== 32'h64) begin errors++; $display("FAIL ff_pc4 got %h exp 64", pc_plus4_out); end
        checks++; if (instr_out !== 32'h13) begin errors++; $display("FAIL ff_instr got %h exp 13", instr_out); end
        checks++; if (i_read !== 1'b0) begin errors++; $display("FAIL ff_read got %b exp 0", i_read); end
    endtask

    task automatic test_stall_hold();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (i_read !== 1'b0) begin errors++; $display("FAIL stall_read[%0d] got %b exp 0", i, i_read); end
            checks++;
            if (valid_out !== 1'b1 || pc_out !== 32'h60 || pc_plus4_out !== 32'h64 || instr_out !== 32'h13) begin
                errors++;
                $display("FAIL stall_slot[%0d] got %b/%h/%h/%h exp 1/60/64/13", i, valid_out, pc_out, pc_plus4_out, instr_out);
            end
        end
        latch_ready = 1'b1;
        tick();
        latch_ready = 1'b0;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL accept_valid got %b exp 0", valid_out); end
        checks++; if (i_read !== 1'b1) begin errors++; $display("FAIL accept_read got %b exp 1", i_read); end
        checks++; if (i_address !== 32'h64) begin errors++; $display("FAIL accept_addr got %h exp 64", i_address); end
    endtask

    task automatic test_back_to_back();
        i_resp = 1'b1; i_rdata = 32'h00100093;
        tick();
        i_resp = 1'b0;
        checks++; if (valid_out !== 1'b1 || pc_out !== 32'h64) begin errors++; $display("FAIL b2b_slot got %b/%h exp 1/64", valid_out, pc_out); end
        checks++; if (instr_out !== 32'h00100093) begin errors++; $display("FAIL b2b_instr got %h exp 00100093", instr_out); end
        latch_ready = 1'b1;
        tick();
        latch_ready = 1'b0;
        checks++; if (i_read !== 1'b1 || i_address !== 32'h68) begin errors++; $display("FAIL b2b_next got %b/%h exp 1/68", i_read, i_address); end
    endtask

    task automatic test_redirect_inflight();
        tick();
        redirect = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i_read !== 1'b1 || i_address !== 32'h68 || valid_out !== 1'b0) begin
                errors++;
                $display("FAIL drop_hold[%0d] got %b/%h/%b exp 1/68/0", i, i_read, i_address, valid_out);
            end
            if (i == 0) tick();
        end
        i_resp = 1'b1; i_rdata = 32'hDEADBEEF;
        tick();
        i_resp = 1'b0;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL drop_valid got %b exp 0", valid_out); end
        checks++; if (i_read !== 1'b1 || i_address !== 32'h200) begin errors++; $display("FAIL drop_next got %b/%h exp 1/200", i_read, i_address); end
    endtask

    task automatic test_redirect_coincident();
        i_resp = 1'b1; i_rdata = 32'hBAADF00D;
        redirect = 1'b1; redirect_pc = 32'h300;
        tick();
        i_resp = 1'b0; redirect = 1'b0;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL coin_valid got %b exp 0", valid_out); end
        checks++; if (i_read !== 1'b1 || i_address !== 32'h300) begin errors++; $display("FAIL coin_addr got %b/%h exp 1/300", i_read, i_address); end
        i_resp = 1'b1; i_rdata = 32'h00000011;
        tick();
        i_resp = 1'b0;
        checks++; if (valid_out !== 1'b1 || pc_out !== 32'h300 || instr_out !== 32'h11) begin
            errors++; $display("FAIL coin_slot got %b/%h/%h exp 1/300/11", valid_out, pc_out, instr_out);
        end
        latch_ready = 1'b1;
        tick();
        latch_ready = 1'b0;
        checks++; if (i_address !== 32'h304) begin errors++; $display("FAIL coin_next got %h exp 304", i_address); end
    endtask

    task automatic test_double_redirect();
        redirect = 1'b1; redirect_pc = 32'h400;
        tick();
        redirect = 1'b0;
        checks++; if (i_address !== 32'h304) begin errors++; $display("FAIL dbl_hold1 got %h exp 304", i_address); end
        redirect = 1'b1; redirect_pc = 32'h503;
        tick();
        redirect = 1'b0;
        checks++; if (i_address !== 32'h304) begin errors++; $display("FAIL dbl_hold2 got %h exp 304", i_address); end
        i_resp = 1'b1; i_rdata = 32'h0000CAFE;
        tick();
        i_resp = 1'b0;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL dbl_valid got %b exp 0", valid_out); end
        checks++; if (i_address !== 32'h500) begin errors++; $display("FAIL dbl_addr got %h exp 500", i_address); end
        i_resp = 1'b1; i_rdata = 32'h00000055;
        tick();
        i_resp = 1'b0;
        checks++; if (valid_out !== 1'b1 || pc_out !== 32'h500 || instr_out !== 32'h55) begin
            errors++; $display("FAIL dbl_slot got %b/%h/%h exp 1/500/55", valid_out, pc_out, instr_out);
        end
    endtask

    task automatic test_redirect_vs_ready_wrap();
        redirect = 1'b1; redirect_pc = 32'hFFFFFFFC; latch_ready = 1'b1;
        tick();
        redirect = 1'b0; latch_ready = 1'b0;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rvr_valid got %b exp 0", valid_out); end
        checks++; if (i_read !== 1'b1 || i_address !== 32'hFFFFFFFC) begin errors++; $display("FAIL rvr_addr got %b/%h exp 1/fffffffc", i_read, i_address); end
        i_resp = 1'b1; i_rdata = 32'h00000077;
        tick();
        i_resp = 1'b0;
        checks++; if (pc_out !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_pc got %h exp fffffffc", pc_out); end
        checks++; if (pc_plus4_out !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got %h exp 0", pc_plus4_out); end
        latch_ready = 1'b1;
        tick();
        latch_ready = 1'b0;
        checks++; if (i_read !== 1'b1 || i_address !== 32'h0) begin errors++; $display("FAIL wrap_next got %b/%h exp 1/0", i_read, i_address); end
    endtask

    task automatic test_reset_midrequest();
        tick();
        rst = 1'b1;
        #1;
        checks++; if (i_read !== 1'b0) begin errors++; $display("FAIL midrst_read got %b exp 0", i_read); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (i_read !== 1'b1 || i_address !== 32'h60) begin errors++; $display("FAIL midrst_addr got %b/%h exp 1/60", i_read, i_address); end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall_hold();
        test_back_to_back();
        test_redirect_inflight();
        test_redirect_coincident();
        test_double_redirect();
        test_redirect_vs_ready_wrap();
        test_reset_midrequest();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
